// File: rtl/cpu16_io_port.sv
// CPU-side I/O port: RX and TX FIFOs between the CPU IN/OUT states and external
// valid/ready handshakes, with a small control FSM stalling the CPU when needed.
//
// state    | meaning
// IDLE     | no CPU request outstanding; IN/OUT serviced immediately when possible
// WAIT_IN  | CPU IN stalled until the RX FIFO holds a word
// WAIT_OUT | CPU OUT stalled with its word in the pending register until TX has room
module cpu16_io_port #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_in_req,
  output logic [WIDTH-1:0]         cpu_in_data,
  output logic                     cpu_in_valid,
  input  logic                     cpu_out_req,
  input  logic [WIDTH-1:0]         cpu_out_data,
  output logic                     cpu_busy,
  input  logic                     ext_rx_valid,
  input  logic [WIDTH-1:0]         ext_rx_data,
  output logic                     ext_rx_ready,
  output logic                     ext_tx_valid,
  output logic [WIDTH-1:0]         ext_tx_data,
  input  logic                     ext_tx_ready,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic                     protocol_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, WAIT_IN, WAIT_OUT} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] rx_mem [DEPTH];
  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [AW-1:0]    rx_wr, rx_rd, tx_wr, tx_rd;
  logic [WIDTH-1:0] pend_data, tx_wdata;
  logic             rx_push, rx_pop, tx_push, tx_pop;
  logic             pend_load, err_set;

  assign ext_rx_ready = (rx_count != FULL);
  assign ext_tx_valid = (tx_count != '0);
  assign ext_tx_data  = tx_mem[tx_rd];
  assign cpu_busy     = (state != IDLE);
  assign rx_push      = ext_rx_valid && ext_rx_ready;
  assign tx_pop       = ext_tx_valid && ext_tx_ready;

  // Decisions use registered counts, so a word entering an empty RX FIFO is never
  // popped on the same edge and a full TX FIFO stalls even if it drains that edge.
  always_comb begin
    state_nxt = state;
    rx_pop    = 1'b0;
    tx_push   = 1'b0;
    tx_wdata  = cpu_out_data;
    pend_load = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_in_req) begin
          err_set = cpu_out_req;
          if (rx_count != '0) rx_pop = 1'b1;
          else                state_nxt = WAIT_IN;
        end else if (cpu_out_req) begin
          if (tx_count != FULL) begin
            tx_push = 1'b1;
          end else begin
            pend_load = 1'b1;
            state_nxt = WAIT_OUT;
          end
        end
      end
      WAIT_IN: begin
        err_set = cpu_in_req || cpu_out_req;
        if (rx_count != '0) begin
          rx_pop    = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_OUT: begin
        err_set  = cpu_in_req || cpu_out_req;
        tx_wdata = pend_data;
        if (tx_count != FULL) begin
          tx_push   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rx_wr        <= '0;
      rx_rd        <= '0;
      tx_wr        <= '0;
      tx_rd        <= '0;
      rx_count     <= '0;
      tx_count     <= '0;
      cpu_in_data  <= '0;
      cpu_in_valid <= 1'b0;
      pend_data    <= '0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      cpu_in_valid <= rx_pop;
      if (rx_pop)    cpu_in_data <= rx_mem[rx_rd];
      if (pend_load) pend_data   <= cpu_out_data;
      if (err_set)   protocol_err <= 1'b1;
      if (rx_push)   rx_wr <= rx_wr + 1'b1;
      if (rx_pop)    rx_rd <= rx_rd + 1'b1;
      if (tx_push)   tx_wr <= tx_wr + 1'b1;
      if (tx_pop)    tx_rd <= tx_rd + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // Storage needs no reset: counts gate every read of stale entries.
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr] <= ext_rx_data;
    if (tx_push) tx_mem[tx_wr] <= tx_wdata;
  end

endmodule

// File: tb/tb_cpu16_io_port.sv
// Self-checking bench for cpu16_io_port: directed scenarios plus a randomized run
// against a queue-based model of the port's behaviour.
module tb_cpu16_io_port;
  localparam int DEPTH = 4;

  logic        clock, reset;
  logic        cpu_in_req, cpu_in_valid, cpu_out_req, cpu_busy;
  logic [15:0] cpu_in_data, cpu_out_data;
  logic        ext_rx_valid, ext_rx_ready, ext_tx_valid, ext_tx_ready;
  logic [15:0] ext_rx_data, ext_tx_data;
  logic [2:0]  rx_count, tx_count;
  logic        protocol_err;

  cpu16_io_port #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .cpu_in_req(cpu_in_req), .cpu_in_data(cpu_in_data), .cpu_in_valid(cpu_in_valid),
    .cpu_out_req(cpu_out_req), .cpu_out_data(cpu_out_data), .cpu_busy(cpu_busy),
    .ext_rx_valid(ext_rx_valid), .ext_rx_data(ext_rx_data), .ext_rx_ready(ext_rx_ready),
    .ext_tx_valid(ext_tx_valid), .ext_tx_data(ext_tx_data), .ext_tx_ready(ext_tx_ready),
    .rx_count(rx_count), .tx_count(tx_count), .protocol_err(protocol_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural model
  logic [15:0] rxq[$];
  logic [15:0] txq[$];
  logic        m_wait_in, m_wait_out, m_err, m_valid, m_pop;
  logic [15:0] m_pend, m_data, m_word;
  logic        obs_pop;
  logic [15:0] obs_word;

  task automatic model_clear();
    rxq.delete(); txq.delete();
    m_wait_in = 0; m_wait_out = 0; m_err = 0; m_valid = 0;
    m_pend = '0; m_data = '0; m_pop = 0; m_word = '0;
  endtask

  // Drive one cycle of inputs, advance the model, step past the next rising edge.
  task automatic cycle(input logic ir, input logic orq, input logic [15:0] od,
                       input logic rv, input logic [15:0] rd, input logic tr);
    logic busy, deliver, opush, rpush;
    logic [15:0] dword, oword;
    int rxn, txn;
    cpu_in_req = ir; cpu_out_req = orq; cpu_out_data = od;
    ext_rx_valid = rv; ext_rx_data = rd; ext_tx_ready = tr;
    #1;
    obs_pop  = ext_tx_valid && ext_tx_ready;
    obs_word = ext_tx_data;
    busy = m_wait_in || m_wait_out;
    rxn = rxq.size(); txn = txq.size();
    rpush = rv && (rxn < DEPTH);
    m_pop = tr && (txn > 0);
    if (m_pop) m_word = txq[0];
    deliver = ((!busy && ir) || m_wait_in) && (rxn > 0);
    dword = (rxn > 0) ? rxq[0] : 16'h0;
    opush = ((!busy && orq && !ir) || m_wait_out) && (txn < DEPTH);
    oword = m_wait_out ? m_pend : od;
    if ((busy && (ir || orq)) || (!busy && ir && orq)) m_err = 1;
    if (!busy && ir && rxn == 0) m_wait_in = 1;
    else if (m_wait_in && rxn > 0) m_wait_in = 0;
    if (!busy && orq && !ir && txn == DEPTH) begin
      m_wait_out = 1; m_pend = od;
    end else if (m_wait_out && txn < DEPTH) m_wait_out = 0;
    if (deliver) void'(rxq.pop_front());
    if (rpush) rxq.push_back(rd);
    if (m_pop) void'(txq.pop_front());
    if (opush) txq.push_back(oword);
    m_valid = deliver;
    if (deliver) m_data = dword;
    @(posedge clock); #1;
  endtask

  task automatic rst_assert();
    cpu_in_req = 0; cpu_out_req = 0; ext_rx_valid = 0; ext_tx_ready = 0;
    reset = 1'b1;
    #1;
    model_clear();
  endtask

  task automatic rst_release();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    cpu_out_data = '0; ext_rx_data = '0;
    rst_assert();
    checks++;
    if (ext_rx_ready !== 1'b1 || ext_tx_valid !== 1'b0 || cpu_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake got rdy=%b txv=%b busy=%b exp 1 0 0", ext_rx_ready, ext_tx_valid, cpu_busy);
    end
    checks++;
    if (rx_count !== 3'd0 || tx_count !== 3'd0 || cpu_in_valid !== 1'b0 ||
        cpu_in_data !== 16'h0 || protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got rx=%0d tx=%0d v=%b d=%h err=%b exp 0 0 0 0000 0",
               rx_count, tx_count, cpu_in_valid, cpu_in_data, protocol_err);
    end
    rst_release();
  endtask

  task automatic test_in_fifo();
    cycle(0, 0, 0, 1, 16'h1234, 0);
    cycle(0, 0, 0, 1, 16'hABCD, 0);
    cycle(1, 0, 0, 0, 0, 0);
    checks++;
    if (cpu_in_valid !== 1'b1 || cpu_in_data !== 16'h1234) begin
      errors++;
      $display("FAIL in_first got v=%b d=%h exp 1 1234", cpu_in_valid, cpu_in_data);
    end
    cycle(1, 0, 0, 0, 0, 0);
    checks++;
    if (cpu_in_valid !== 1'b1 || cpu_in_data !== 16'hABCD || rx_count !== 3'd0) begin
      errors++;
      $display("FAIL in_second got v=%b d=%h cnt=%0d exp 1 abcd 0", cpu_in_valid, cpu_in_data, rx_count);
    end
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (cpu_in_valid !== 1'b0 || cpu_in_data !== 16'hABCD) begin
      errors++;
      $display("FAIL in_pulse_end got v=%b d=%h exp 0 abcd", cpu_in_valid, cpu_in_data);
    end
  endtask

  task automatic test_in_wait();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (cpu_busy !== 1'b1) begin
      errors++;
      $display("FAIL in_wait_busy got %b exp 1", cpu_busy);
    end
    cycle(0, 0, 0, 1, 16'h00FF, 0);
    checks++;
    if (cpu_in_valid !== 1'b0 || cpu_busy !== 1'b1 || rx_count !== 3'd1) begin
      errors++;
      $display("FAIL in_wait_push_edge got v=%b busy=%b cnt=%0d exp 0 1 1", cpu_in_valid, cpu_busy, rx_count);
    end
    cycle(0, 0, 0, 0, 0, 0);
    checks++;
    if (cpu_in_valid !== 1'b1 || cpu_in_data !== 16'h00FF || cpu_busy !== 1'b0 || rx_count !== 3'd0) begin
      errors++;
      $display("FAIL in_wait_deliver got v=%b d=%h busy=%b cnt=%0d exp 1 00ff 0 0",
               cpu_in_valid, cpu_in_data, cpu_busy, rx_count);
    end
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_out_full();
    logic [15:0] got[$];
    for (int i = 1; i <= 5; i++) cycle(0, 1, 16'(i), 0, 0, 0);
    checks++;
    if (tx_count !== 3'd4 || cpu_busy !== 1'b1) begin
      errors++;
      $display("FAIL out_full got cnt=%0d busy=%b exp 4 1", tx_count, cpu_busy);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, 0, 0, 1);
      if (obs_pop) got.push_back(obs_word);
    end
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL out_sink_count got %0d exp 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] !== 16'(i + 1)) begin
          errors++;
          $display("FAIL out_sink_order[%0d] got %h exp %h", i, got[i], 16'(i + 1));
        end
      end
    end
    checks++;
    if (cpu_busy !== 1'b0 || ext_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL out_drained got busy=%b txv=%b exp 0 0", cpu_busy, ext_tx_valid);
    end
  endtask

  task automatic test_rx_full();
    logic [15:0] exp_order[5];
    exp_order = '{16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3, 16'hB0B0};
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, exp_order[i], 0);
    checks++;
    if (ext_rx_ready !== 1'b0 || rx_count !== 3'd4) begin
      errors++;
      $display("FAIL rx_full got rdy=%b cnt=%0d exp 0 4", ext_rx_ready, rx_count);
    end
    cycle(0, 0, 0, 1, 16'h5555, 0);
    checks++;
    if (rx_count !== 3'd4) begin
      errors++;
      $display("FAIL rx_fifth_rejected got cnt=%0d exp 4", rx_count);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 0, 0, 0, 0);
      checks++;
      if (cpu_in_valid !== 1'b1 || cpu_in_data !== exp_order[i]) begin
        errors++;
        $display("FAIL rx_drain[%0d] got v=%b d=%h exp 1 %h", i, cpu_in_valid, cpu_in_data, exp_order[i]);
      end
    end
    cycle(1, 0, 0, 1, exp_order[4], 0);
    checks++;
    if (rx_count !== 3'd2 || cpu_in_data !== exp_order[2]) begin
      errors++;
      $display("FAIL rx_push_pop got cnt=%0d d=%h exp 2 %h", rx_count, cpu_in_data, exp_order[2]);
    end
    for (int i = 3; i < 5; i++) begin
      cycle(1, 0, 0, 0, 0, 0);
      checks++;
      if (cpu_in_valid !== 1'b1 || cpu_in_data !== exp_order[i]) begin
        errors++;
        $display("FAIL rx_order[%0d] got v=%b d=%h exp 1 %h", i, cpu_in_valid, cpu_in_data, exp_order[i]);
      end
    end
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_wait_out();
    int seen;
    seen = 0;
    for (int i = 0; i < 4; i++) cycle(0, 1, 16'h0010 + 16'(i), 0, 0, 0);
    cycle(0, 1, 16'hDEAD, 0, 0, 0);
    checks++;
    if (cpu_busy !== 1'b1 || tx_count !== 3'd4) begin
      errors++;
      $display("FAIL wait_out_entry got busy=%b cnt=%0d exp 1 4", cpu_busy, tx_count);
    end
    #3;
    rst_assert();
    checks++;
    if (tx_count !== 3'd0 || ext_tx_valid !== 1'b0 || cpu_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_wait_out got cnt=%0d txv=%b busy=%b exp 0 0 0", tx_count, ext_tx_valid, cpu_busy);
    end
    rst_release();
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 0, 1);
      if (obs_pop || ext_tx_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL pending_discarded got %0d tx cycles exp 0", seen);
    end
  endtask

  task automatic test_conflict();
    cycle(0, 0, 0, 1, 16'h4242, 0);
    cycle(1, 1, 16'h9999, 0, 0, 0);
    checks++;
    if (cpu_in_valid !== 1'b1 || cpu_in_data !== 16'h4242 || tx_count !== 3'd0 || protocol_err !== 1'b1) begin
      errors++;
      $display("FAIL conflict got v=%b d=%h txcnt=%0d err=%b exp 1 4242 0 1",
               cpu_in_valid, cpu_in_data, tx_count, protocol_err);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1);
    checks++;
    if (protocol_err !== 1'b1 || ext_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL conflict_sticky got err=%b txv=%b exp 1 0", protocol_err, ext_tx_valid);
    end
    rst_assert();
    checks++;
    if (protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared got %b exp 0", protocol_err);
    end
    rst_release();
  endtask

  task automatic test_random();
    logic ir, orq, busy;
    for (int n = 0; n < 2000; n++) begin
      busy = m_wait_in || m_wait_out;
      ir  = ($urandom_range(99) < (busy ? 2 : 20));
      orq = ($urandom_range(99) < (busy ? 2 : 20));
      cycle(ir, orq, 16'($urandom), ($urandom_range(99) < 50), 16'($urandom),
            ($urandom_range(99) < 40));
      checks++;
      if (cpu_in_valid !== m_valid || (m_valid && cpu_in_data !== m_data)) begin
        errors++;
        $display("FAIL rnd_in cyc %0d got v=%b d=%h exp %b %h", n, cpu_in_valid, cpu_in_data, m_valid, m_data);
      end
      checks++;
      if (obs_pop !== m_pop || (m_pop && obs_word !== m_word)) begin
        errors++;
        $display("FAIL rnd_tx cyc %0d got pop=%b d=%h exp %b %h", n, obs_pop, obs_word, m_pop, m_word);
      end
      checks++;
      if (rx_count !== 3'(rxq.size()) || tx_count !== 3'(txq.size())) begin
        errors++;
        $display("FAIL rnd_counts cyc %0d got rx=%0d tx=%0d exp %0d %0d", n, rx_count, tx_count, rxq.size(), txq.size());
      end
      checks++;
      if (cpu_busy !== (m_wait_in || m_wait_out) || protocol_err !== m_err ||
          ext_rx_ready !== (rxq.size() != DEPTH) || ext_tx_valid !== (txq.size() != 0)) begin
        errors++;
        $display("FAIL rnd_status cyc %0d got busy=%b err=%b rdy=%b txv=%b exp %b %b %b %b", n,
                 cpu_busy, protocol_err, ext_rx_ready, ext_tx_valid, m_wait_in || m_wait_out,
                 m_err, rxq.size() != DEPTH, txq.size() != 0);
      end
    end
  endtask

  initial begin
    model_clear();
    cpu_in_req = 0; cpu_out_req = 0; cpu_out_data = '0;
    ext_rx_valid = 0; ext_rx_data = '0; ext_tx_ready = 0;
    test_reset();
    test_in_fifo();
    test_in_wait();
    test_out_full();
    test_rx_full();
    test_reset_wait_out();
    test_conflict();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
